// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter: access-size encodings,
// FSM state enum, the latched request record and mask decode helpers.
package dmem_pkg;

    localparam logic [2:0] MASK_W  = 3'b000;
    localparam logic [2:0] MASK_HS = 3'b001;
    localparam logic [2:0] MASK_BS = 3'b010;
    localparam logic [2:0] MASK_HU = 3'b100;
    localparam logic [2:0] MASK_BU = 3'b101;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        READ  = 3'd2,
        WRITE = 3'd3,
        RESP  = 3'd4
    } state_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  mask;
    } req_t;

    function automatic logic mask_is_half(input logic [2:0] m);
        return (m == MASK_HS) || (m == MASK_HU);
    endfunction

    function automatic logic mask_is_byte(input logic [2:0] m);
        return (m == MASK_BS) || (m == MASK_BU);
    endfunction

    function automatic logic mask_is_legal(input logic [2:0] m);
        return (m == MASK_W) || mask_is_half(m) || mask_is_byte(m);
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane logic: load extract/extend and sub-word store merge
// against one 32-bit memory word.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  mask,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [4:0]  shamt;
    logic [31:0] shifted;
    logic [31:0] lane;

    always_comb begin
        shamt     = {offset, 3'b000};
        shifted   = word >> shamt;
        load_data = word;
        lane      = 32'hFFFF_FFFF;
        if (mask_is_byte(mask)) begin
            lane      = 32'h0000_00FF;
            load_data = (mask == MASK_BU) ? {24'h0, shifted[7:0]}
                                          : {{24{shifted[7]}}, shifted[7:0]};
        end else if (mask_is_half(mask)) begin
            lane      = 32'h0000_FFFF;
            load_data = (mask == MASK_HU) ? {16'h0, shifted[15:0]}
                                          : {{16{shifted[15]}}, shifted[15:0]};
        end
        // A full-word lane with zero shift makes the merge collapse to wdata.
        merged = (word & ~(lane << shamt)) | ((wdata & lane) << shamt);
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for a single-port word memory; sub-word stores use
// read-modify-write. Define DMEM_ARB_FIXED_PRIO_EN for fixed port-0 priority.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_i,
    input  logic        we0_i,
    input  logic [31:0] addr0_i,
    input  logic [31:0] wdata0_i,
    input  logic [2:0]  mask0_i,
    output logic        ack0_o,
    output logic        err0_o,
    output logic [31:0] rdata0_o,
    input  logic        req1_i,
    input  logic        we1_i,
    input  logic [31:0] addr1_i,
    input  logic [31:0] wdata1_i,
    input  logic [2:0]  mask1_i,
    output logic        ack1_o,
    output logic        err1_o,
    output logic [31:0] rdata1_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    output logic [2:0]  mem_mask_o,
    output logic        mem_rd_wr_o,
    output logic        mem_cs_o,
    output state_t      dbg_state
);

    // Handshake: a requester raises reqN with we/addr/wdata/mask stable and holds
    // them until its one-cycle ackN; a request still high after ack is a new one
    // and is only considered again from IDLE.

    state_t      state;
    req_t        req_q;
    req_t        sel_req;
    logic        gnt;
    logic        pick;
    logic        bad;
    logic [31:0] widx;
    logic [31:0] load_data;
    logic [31:0] merged;
    logic        resp_fire;
    logic        resp_err;
    logic [31:0] resp_data;
`ifndef DMEM_ARB_FIXED_PRIO_EN
    logic        rr;
`endif

    assign mem_mask_o = MASK_W;
    assign dbg_state  = state;
    assign widx       = {{(32-AW){1'b0}}, req_q.addr[AW+1:2]};

    always_comb begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
        pick = !req0_i;
`else
        pick = (req0_i && req1_i) ? rr : req1_i;
`endif
        sel_req = pick ? '{we1_i, addr1_i, wdata1_i, mask1_i}
                       : '{we0_i, addr0_i, wdata0_i, mask0_i};
    end

    always_comb begin
        bad = !mask_is_legal(req_q.mask)
           || ((req_q.mask == MASK_W) && (req_q.addr[1:0] != 2'b00))
           || (mask_is_half(req_q.mask) && req_q.addr[0])
           || (req_q.addr[31:2] >= 30'(DEPTH));
    end

    dmem_lane_align u_lane (
        .word      (mem_rdata_i),
        .wdata     (req_q.wdata),
        .offset    (req_q.addr[1:0]),
        .mask      (req_q.mask),
        .load_data (load_data),
        .merged    (merged)
    );

    // Response is raised on the edge that enters RESP, so ack lives in RESP only.
    always_comb begin
        resp_fire = 1'b0;
        resp_err  = 1'b0;
        resp_data = 32'h0;
        case (state)
            CHECK: if (bad) begin
                resp_fire = 1'b1;
                resp_err  = 1'b1;
            end
            READ: if (!req_q.we) begin
                resp_fire = 1'b1;
                resp_data = load_data;
            end
            WRITE:   resp_fire = 1'b1;
            default: resp_fire = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            req_q       <= '0;
            gnt         <= 1'b0;
            ack0_o      <= 1'b0;
            ack1_o      <= 1'b0;
            err0_o      <= 1'b0;
            err1_o      <= 1'b0;
            rdata0_o    <= 32'h0;
            rdata1_o    <= 32'h0;
            mem_cs_o    <= 1'b1;
            mem_rd_wr_o <= 1'b1;
            mem_addr_o  <= 32'h0;
            mem_wdata_o <= 32'h0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
            rr          <= 1'b0;
`endif
        end else begin
            ack0_o      <= 1'b0;
            ack1_o      <= 1'b0;
            err0_o      <= 1'b0;
            err1_o      <= 1'b0;
            mem_cs_o    <= 1'b1;
            mem_rd_wr_o <= 1'b1;
            case (state)
                IDLE: if (req0_i || req1_i) begin
                    gnt   <= pick;
                    req_q <= sel_req;
`ifndef DMEM_ARB_FIXED_PRIO_EN
                    rr    <= ~pick;
`endif
                    state <= CHECK;
                end
                CHECK: begin
                    if (bad) begin
                        state <= RESP;
                    end else if (!req_q.we || (req_q.mask != MASK_W)) begin
                        state      <= READ;
                        mem_cs_o   <= 1'b0;
                        mem_addr_o <= widx;
                    end else begin
                        state       <= WRITE;
                        mem_cs_o    <= 1'b0;
                        mem_rd_wr_o <= 1'b0;
                        mem_addr_o  <= widx;
                        mem_wdata_o <= req_q.wdata;
                    end
                end
                READ: begin
                    if (req_q.we) begin
                        state       <= WRITE;
                        mem_cs_o    <= 1'b0;
                        mem_rd_wr_o <= 1'b0;
                        mem_wdata_o <= merged;
                    end else begin
                        state <= RESP;
                    end
                end
                WRITE:   state <= RESP;
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
            if (resp_fire) begin
                if (gnt) begin
                    ack1_o   <= 1'b1;
                    err1_o   <= resp_err;
                    rdata1_o <= resp_data;
                end else begin
                    ack0_o   <= 1'b1;
                    err0_o   <= resp_err;
                    rdata0_o <= resp_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: behavioural word memory, per-port
// expected-response queues, latency/grant-order checks and a final summary.
module tb_dmem_arbiter;
    import dmem_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [31:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;
    logic [2:0]  mask0 = '0, mask1 = '0;
    logic        ack0_o, err0_o, ack1_o, err1_o;
    logic [31:0] rdata0_o, rdata1_o;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata;
    logic [2:0]  mem_mask_o;
    logic        mem_rd_wr_o, mem_cs_o;
    state_t      dbg_state;

    logic [31:0] mem [16];
    logic        bd_en = 1'b0;
    logic [3:0]  bd_addr = '0;
    logic [31:0] bd_data = '0;
    int          cs_cnt = 0, wr_cnt = 0, ack_cnt = 0;
    logic [63:0] ack_hist = '0;
    logic [32:0] exp_q0[$];
    logic [32:0] exp_q1[$];
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.DEPTH(16), .AW(4)) dut (
        .clk(clk), .rst(rst),
        .req0_i(req0), .we0_i(we0), .addr0_i(addr0), .wdata0_i(wdata0), .mask0_i(mask0),
        .ack0_o(ack0_o), .err0_o(err0_o), .rdata0_o(rdata0_o),
        .req1_i(req1), .we1_i(we1), .addr1_i(addr1), .wdata1_i(wdata1), .mask1_i(mask1),
        .ack1_o(ack1_o), .err1_o(err1_o), .rdata1_o(rdata1_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata),
        .mem_mask_o(mem_mask_o), .mem_rd_wr_o(mem_rd_wr_o), .mem_cs_o(mem_cs_o),
        .dbg_state(dbg_state)
    );

    assign mem_rdata = mem[mem_addr_o[3:0]];

    always @(posedge clk) begin
        if (bd_en) mem[bd_addr] <= bd_data;
        else if (!mem_cs_o && !mem_rd_wr_o) begin
            mem[mem_addr_o[3:0]] <= mem_wdata_o;
            wr_cnt <= wr_cnt + 1;
        end
        if (!mem_cs_o) cs_cnt <= cs_cnt + 1;
    end

    always @(negedge clk) begin
        if (ack0_o) begin ack_hist = {ack_hist[62:0], 1'b0}; ack_cnt++; end
        if (ack1_o) begin ack_hist = {ack_hist[62:0], 1'b1}; ack_cnt++; end
    end

    function automatic logic [31:0] load_model(input logic [31:0] w, input logic [1:0] off,
                                               input logic [2:0] m);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0: b = w[7:0];
            2'd1: b = w[15:8];
            2'd2: b = w[23:16];
            default: b = w[31:24];
        endcase
        h = off[1] ? w[31:16] : w[15:0];
        case (m)
            3'b000:  return w;
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {16'h0, h};
            3'b010:  return {{24{b[7]}}, b};
            3'b101:  return {24'h0, b};
            default: return 32'h0;
        endcase
    endfunction

    task automatic preload(input int a, input logic [31:0] d);
        @(negedge clk);
        bd_en = 1'b1; bd_addr = a[3:0]; bd_data = d;
        @(negedge clk);
        bd_en = 1'b0;
    endtask

    task automatic set_req(input bit port, input logic r, input logic we, input logic [31:0] a,
                           input logic [31:0] d, input logic [2:0] m);
        if (port) begin req1 = r; we1 = we; addr1 = a; wdata1 = d; mask1 = m; end
        else      begin req0 = r; we0 = we; addr0 = a; wdata0 = d; mask0 = m; end
    endtask

    task automatic single_txn(input bit port, input logic we, input logic [31:0] a,
                              input logic [31:0] d, input logic [2:0] m, input logic exp_err,
                              input logic [31:0] exp_rd, input int exp_lat, input string name);
        int          edges;
        bit          got, other;
        logic [32:0] exp;
        logic        act_err;
        logic [31:0] act_rd;
        @(negedge clk);
        set_req(port, 1'b1, we, a, d, m);
        if (port) exp_q1.push_back({exp_err, exp_rd}); else exp_q0.push_back({exp_err, exp_rd});
        edges = 0; got = 0; other = 0;
        while (!got && edges < 20) begin
            @(negedge clk);
            edges++;
            if (port ? ack1_o : ack0_o) got = 1;
            if (port ? ack0_o : ack1_o) other = 1;
        end
        act_err = port ? err1_o : err0_o;
        act_rd  = port ? rdata1_o : rdata0_o;
        set_req(port, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        exp = port ? exp_q1.pop_front() : exp_q0.pop_front();
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s_ack: no ack within %0d cycles, required at cycle %0d", name, edges, exp_lat);
            return;
        end
        checks++;
        if (edges != exp_lat) begin
            errors++;
            $display("FAIL %s_latency: ack at cycle %0d, required %0d", name, edges, exp_lat);
        end
        checks++;
        if (other) begin
            errors++;
            $display("FAIL %s_other_ack: other port acked, required no ack", name);
        end
        checks++;
        if (act_err !== exp[32]) begin
            errors++;
            $display("FAIL %s_err: got %0b, required %0b", name, act_err, exp[32]);
        end
        if (!we || exp_err) begin
            checks++;
            if (act_rd !== exp[31:0]) begin
                errors++;
                $display("FAIL %s_rdata: got %08h, required %08h", name, act_rd, exp[31:0]);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if ({ack0_o, ack1_o, err0_o, err1_o} !== 4'b0000) begin
            errors++; $display("FAIL reset_ack_err: got %04b, required 0000", {ack0_o, ack1_o, err0_o, err1_o}); end
        checks++; if (rdata0_o !== 32'h0 || rdata1_o !== 32'h0) begin
            errors++; $display("FAIL reset_rdata: got %08h/%08h, required 0/0", rdata0_o, rdata1_o); end
        checks++; if (mem_cs_o !== 1'b1 || mem_rd_wr_o !== 1'b1) begin
            errors++; $display("FAIL reset_cs_rdwr: got %0b%0b, required 11", mem_cs_o, mem_rd_wr_o); end
        checks++; if (mem_addr_o !== 32'h0 || mem_wdata_o !== 32'h0 || mem_mask_o !== 3'b000) begin
            errors++; $display("FAIL reset_mem_bus: got %08h %08h %03b, required zeros", mem_addr_o, mem_wdata_o, mem_mask_o); end
        checks++; if (dbg_state !== IDLE) begin
            errors++; $display("FAIL reset_state: got %0d, required %0d", dbg_state, IDLE); end
    endtask

    task automatic test_word_load();
        preload(2, 32'hDEADBEEF);
        single_txn(1'b0, 1'b0, 32'h8, 32'h0, 3'b000, 1'b0, 32'hDEADBEEF, 3, "word_load");
    endtask

    task automatic test_stores();
        int cs0, wr0;
        preload(1, 32'h11223344);
        cs0 = cs_cnt; wr0 = wr_cnt;
        single_txn(1'b1, 1'b1, 32'h6, 32'h0000_00AB, 3'b010, 1'b0, 32'h0, 4, "byte_store");
        checks++; if (mem[1] !== 32'h11AB3344) begin
            errors++; $display("FAIL byte_store_mem: got %08h, required 11ab3344", mem[1]); end
        checks++; if (cs_cnt - cs0 != 2 || wr_cnt - wr0 != 1) begin
            errors++; $display("FAIL byte_store_cycles: cs %0d writes %0d, required cs 2 writes 1", cs_cnt - cs0, wr_cnt - wr0); end
        single_txn(1'b0, 1'b1, 32'h14, 32'h12345678, 3'b000, 1'b0, 32'h0, 3, "word_store");
        checks++; if (mem[5] !== 32'h12345678) begin
            errors++; $display("FAIL word_store_mem: got %08h, required 12345678", mem[5]); end
        single_txn(1'b1, 1'b1, 32'h16, 32'hFFFFBEEF, 3'b100, 1'b0, 32'h0, 4, "half_store");
        checks++; if (mem[5] !== 32'hBEEF5678) begin
            errors++; $display("FAIL half_store_mem: got %08h, required beef5678", mem[5]); end
    endtask

    task automatic test_load_ext();
        logic [2:0]  masks [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        logic [2:0]  m;
        logic [1:0]  off;
        logic [31:0] w;
        int          k;
        preload(0, 32'h0000F080);
        single_txn(1'b0, 1'b0, 32'h0, 32'h0, 3'b001, 1'b0, 32'hFFFFF080, 3, "load_hs");
        single_txn(1'b1, 1'b0, 32'h0, 32'h0, 3'b101, 1'b0, 32'h00000080, 3, "load_bu");
        single_txn(1'b0, 1'b0, 32'h1, 32'h0, 3'b010, 1'b0, 32'hFFFFFFF0, 3, "load_bs");
        single_txn(1'b1, 1'b0, 32'h2, 32'h0, 3'b100, 1'b0, 32'h00000000, 3, "load_hu");
        for (int i = 0; i < 6; i++) begin
            k = $urandom_range(0, 15);
            m = masks[$urandom_range(0, 4)];
            w = $urandom;
            if (m == 3'b000) off = 2'd0;
            else if (m == 3'b001 || m == 3'b100) off = 2'($urandom_range(0, 1) * 2);
            else off = 2'($urandom_range(0, 3));
            preload(k, w);
            single_txn(1'(i % 2), 1'b0, {26'h0, k[3:0], off}, 32'h0, m, 1'b0,
                       load_model(w, off, m), 3, "load_rand");
        end
    endtask

    task automatic test_errors();
        int cs0, wr0;
        cs0 = cs_cnt; wr0 = wr_cnt;
        single_txn(1'b0, 1'b0, 32'h2,  32'h0, 3'b000, 1'b1, 32'h0, 2, "err_word_misalign");
        single_txn(1'b1, 1'b0, 32'h40, 32'h0, 3'b000, 1'b1, 32'h0, 2, "err_range");
        single_txn(1'b0, 1'b0, 32'h1,  32'h0, 3'b001, 1'b1, 32'h0, 2, "err_half_misalign");
        single_txn(1'b1, 1'b0, 32'h0,  32'h0, 3'b011, 1'b1, 32'h0, 2, "err_mask");
        single_txn(1'b0, 1'b1, 32'h80, 32'h5, 3'b010, 1'b1, 32'h0, 2, "err_store_range");
        checks++; if (cs_cnt != cs0 || wr_cnt != wr0) begin
            errors++; $display("FAIL err_no_cs: cs %0d writes %0d, required 0 and 0", cs_cnt - cs0, wr_cnt - wr0); end
    endtask

    task automatic test_back_to_back();
        int          edges;
        logic [32:0] exp;
        preload(8, 32'hCAFE0008);
        preload(9, 32'hCAFE0009);
        @(negedge clk);
        for (int t = 0; t < 2; t++) begin
            set_req(1'b0, 1'b1, 1'b0, 32'h20 + 32'(t * 4), 32'h0, 3'b000);
            exp_q0.push_back({1'b0, 32'hCAFE0008 + 32'(t)});
            edges = 0;
            do begin @(negedge clk); edges++; end while (!ack0_o && edges < 20);
            exp = exp_q0.pop_front();
            checks++; if (edges != 3 + t) begin
                errors++; $display("FAIL b2b_latency%0d: ack at cycle %0d, required %0d", t, edges, 3 + t); end
            checks++; if (rdata0_o !== exp[31:0]) begin
                errors++; $display("FAIL b2b_rdata%0d: got %08h, required %08h", t, rdata0_o, exp[31:0]); end
        end
        set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    endtask

    task automatic port_stream(input bit port, input int n);
        int          c;
        logic [32:0] exp;
        logic [31:0] a;
        for (int i = 0; i < n; i++) begin
            a = port ? 32'(48 + 4 * i) : 32'(32 + 4 * i);
            set_req(port, 1'b1, 1'b0, a, 32'h0, 3'b000);
            if (port) exp_q1.push_back({1'b0, 32'hA000_0000 + a});
            else      exp_q0.push_back({1'b0, 32'hA000_0000 + a});
            c = 0;
            do begin @(negedge clk); c++; end while (!(port ? ack1_o : ack0_o) && c < 40);
            exp = port ? exp_q1.pop_front() : exp_q0.pop_front();
            checks++;
            if (c >= 40) begin
                errors++; $display("FAIL stream%0d_ack: no ack within %0d cycles", port, c);
            end else if ((port ? rdata1_o : rdata0_o) !== exp[31:0]) begin
                errors++; $display("FAIL stream%0d_rdata: got %08h, required %08h", port,
                                   port ? rdata1_o : rdata0_o, exp[31:0]);
            end
        end
        set_req(port, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    endtask

    task automatic test_arbitration();
        localparam int N = 4;
        logic prev, exp_g, got_g;
        int   cnt0;
        for (int k = 8; k < 16; k++) preload(k, 32'hA000_0000 + 32'(k * 4));
        @(negedge clk); #1;
        prev = ack_hist[0];
        cnt0 = ack_cnt;
        fork
            port_stream(1'b0, N);
            port_stream(1'b1, N);
        join
        @(negedge clk); #1;
        checks++; if (ack_cnt - cnt0 != 2 * N) begin
            errors++; $display("FAIL arb_count: got %0d acks, required %0d", ack_cnt - cnt0, 2 * N); end
        for (int i = 0; i < 2 * N; i++) begin
            got_g = ack_hist[2 * N - 1 - i];
`ifdef DMEM_ARB_FIXED_PRIO_EN
            exp_g = (i >= N);
`else
            exp_g = (~prev) ^ 1'(i % 2);
`endif
            checks++; if (got_g !== exp_g) begin
                errors++; $display("FAIL arb_order[%0d]: granted port %0d, required port %0d", i, got_g, exp_g); end
        end
    endtask

    task automatic test_reset_in_write();
        int  c, acks0, wr0;
        bit  found;
        preload(3, 32'h55667788);
        @(negedge clk);
        set_req(1'b0, 1'b1, 1'b1, 32'hC, 32'h99, 3'b010);
        c = 0; found = 0;
        while (!found && c < 10) begin
            @(negedge clk); c++;
            if (dbg_state == WRITE) found = 1;
        end
        checks++; if (!found) begin
            errors++; $display("FAIL rst_write_reach: WRITE not seen within %0d cycles", c); end
        acks0 = ack_cnt; wr0 = wr_cnt;
        rst = 1'b1;
        #1;
        checks++; if (mem_cs_o !== 1'b1 || mem_rd_wr_o !== 1'b1 || ack0_o !== 1'b0) begin
            errors++; $display("FAIL rst_write_outputs: cs %0b rd_wr %0b ack %0b, required 1 1 0", mem_cs_o, mem_rd_wr_o, ack0_o); end
        checks++; if (mem_addr_o !== 32'h0 || mem_wdata_o !== 32'h0 || dbg_state !== IDLE) begin
            errors++; $display("FAIL rst_write_state: addr %08h wdata %08h state %0d, required 0 0 %0d", mem_addr_o, mem_wdata_o, dbg_state, IDLE); end
        set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        checks++; if (mem[3] !== 32'h55667788 || wr_cnt != wr0) begin
            errors++; $display("FAIL rst_write_mem: got %08h writes %0d, required 55667788 and 0", mem[3], wr_cnt - wr0); end
        checks++; if (ack_cnt != acks0) begin
            errors++; $display("FAIL rst_write_noack: got %0d acks, required 0", ack_cnt - acks0); end
    endtask

    initial begin
        test_reset();
        test_word_load();
        test_stores();
        test_load_ext();
        test_errors();
        test_back_to_back();
        test_arbitration();
        test_reset_in_write();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Sequences and shares the single-port word-organised data memory between two requesters: port 0 (core load/store stage) and port 1 (debug/DMA loader).
- Converts byte-addressed, sub-word requests into word accesses on the memory.
- Sub-word stores are done as read-modify-write; load sign/zero extension happens here.
- Sits between the memory stage and the data memory; the memory itself is always driven with word mask.

Parameters:
- DEPTH, 16, number of 32-bit words in data memory.
- AW, 4, word-index width, equal to clog2(DEPTH).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0_i / req1_i  in  1  request valid; held with its fields stable until the matching ack.
- we0_i / we1_i  in  1  1 = store, 0 = load.
- addr0_i / addr1_i  in  32  byte address.
- wdata0_i / wdata1_i  in  32  store data, right-aligned.
- mask0_i / mask1_i  in  3  access size: 000 word; 001 half signed; 010 byte signed; 100 half unsigned; 101 byte unsigned. Stores ignore bit 2.
- ack0_o / ack1_o  out  1  one-cycle completion pulse.
- err0_o / err1_o  out  1  valid with ack; misaligned, out-of-range or illegal mask.
- rdata0_o / rdata1_o  out  32  load result, extended; valid with ack.
- mem_addr_o  out  32  word index (upper bits zero).
- mem_wdata_o  out  32  full word to write.
- mem_rdata_i  in  32  combinational read word.
- mem_mask_o  out  3  constant 000.
- mem_rd_wr_o  out  1  1 = read, 0 = write.
- mem_cs_o  out  1  active-low chip select.

Behaviour:
- Reset: state IDLE; all ack/err 0; all rdata 0; mem_cs_o 1; mem_rd_wr_o 1; mem_addr_o 0; mem_wdata_o 0; round-robin pointer = port 0. Async reset mid-operation aborts with no memory write; no ack is issued.
- FSM states: IDLE, CHECK, READ, WRITE, RESP.
- IDLE:
  - Round-robin grant; the pointer moves to the other port after every grant.
  - Latch the selected request fields, then go to CHECK.
  - No request: stay in IDLE, cs high.
- CHECK, no memory access:
  - Flag error if any of: word access with addr[1:0] != 0; half access with addr[0] = 1; mask in {011, 110, 111}; addr[31:2] >= DEPTH.
  - Error: go to RESP with err = 1 and rdata = 0.
  - Load or sub-word store: go to READ.
  - Word store: go to WRITE.
- READ:
  - cs = 0, rd_wr = 1; capture mem_rdata_i.
  - Load: extract the byte/half at addr[1:0], sign- or zero-extend per mask, then go to RESP.
  - Sub-word store: merge wdata into the captured word at the byte lane, then go to WRITE.
- WRITE: cs = 0, rd_wr = 0, wdata = merged or full word for exactly one cycle; then RESP.
- RESP: pulse ack (and err if set) plus rdata to the granted port only; return to IDLE. rdata holds its value until the next ack to that port.
- Latency, request first sampled in IDLE (cycle 0) to ack cycle:
  - Load: 3.
  - Word store: 3.
  - Sub-word store: 4.
  - Error: 2.
- Back-to-back: a request held through ack is not re-granted in the ack cycle. It is re-arbitrated in the following IDLE.
- Simultaneous requests: the pointer decides; the loser waits in at most one transaction.
- Memory outputs outside READ/WRITE: cs = 1, rd_wr = 1.

Optional Feature:
- Macro: DMEM_ARB_FIXED_PRIO_EN.
- Defined: port 0 always wins on simultaneous requests; the pointer is unused.
- Undefined: round-robin as above.

Decomposition:
- Shared package dmem_pkg holds:
  - mask encoding constants MASK_W, MASK_HS, MASK_BS, MASK_HU, MASK_BU.
  - state enum.
  - request struct (we, addr, wdata, mask).
- One sub-module, dmem_lane_align, combinational:
  - load extract/extend (word, addr[1:0], mask → rdata).
  - store merge (old word, wdata, addr[1:0], mask → new word).

Test Plan:
- Word load: port 0 load addr 0x8, mask 000, mem word2 = 0xDEADBEEF → ack0 at cycle 3, rdata0 = 0xDEADBEEF, err0 = 0.
- Sub-word store: word1 = 0x11223344; port 1 store byte 0xAB to addr 0x6 → a read cycle, then one write of 0x11AB3344; ack1 at cycle 4.
- Load extension on word 0x0000F080:
  - Half-signed load at addr 0x0 → 0xFFFFF080.
  - Byte-unsigned load at addr 0x0 → 0x00000080.
- Errors, no cs assertion:
  - Word load at addr 0x2 → err, ack at cycle 2.
  - Load at addr 0x40 (DEPTH 16) → err.
- Simultaneous requests:
  - Both ports request continuously → grants alternate 0, 1, 0, 1.
  - With DMEM_ARB_FIXED_PRIO_EN → port 0 is served every transaction.
- Reset in WRITE cycle of a sub-word store → outputs return to reset values immediately, memory word unchanged, no ack.
